// File: rtl/dmem_sram_bridge_pkg.sv
// Shared data-memory map constants, write-buffer payload type and address-range check.
package dmem_sram_bridge_pkg;

    localparam int unsigned DMEM_WORD_BYTES         = 4;
    localparam int unsigned DMEM_WADDR_W            = 30;
    localparam int unsigned DMEM_MEM_WORDS_DEFAULT  = 16384;
    localparam int unsigned DMEM_STARVE_MAX_DEFAULT = 8;

    typedef struct packed {
        logic [DMEM_WADDR_W-1:0] waddr;
        logic [31:0]             data;
        logic [3:0]              strb;
    } wbuf_entry_t;

    // True when a word address falls inside the populated SRAM.
    function automatic logic dmem_addr_ok(input logic [DMEM_WADDR_W-1:0] waddr,
                                          input int unsigned            mem_words);
        return {2'b00, waddr} < mem_words;
    endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// One-entry posted-write buffer plus the byte merge that forwards its
// contents into a read response one cycle after the read is accepted.
module dmem_wbuf
    import dmem_sram_bridge_pkg::*;
(
    input  logic                    clk,
    input  logic                    resetb,
    input  logic                    i_load,
    input  logic [DMEM_WADDR_W-1:0] i_load_waddr,
    input  logic [31:0]             i_load_data,
    input  logic [3:0]              i_load_strb,
    input  logic                    i_drain,
    input  logic                    i_snap,
    input  logic [DMEM_WADDR_W-1:0] i_rd_waddr,
    input  logic [31:0]             i_sram_rdata,
    output logic                    o_valid,
    output logic [DMEM_WADDR_W-1:0] o_waddr,
    output logic [31:0]             o_data,
    output logic [3:0]              o_strb,
    output logic [31:0]             o_merged_c
);

    logic        r_valid;
    wbuf_entry_t r_entry;
    logic [3:0]  r_fwd_strb;
    logic [31:0] r_fwd_data;

    // A refill in the drain cycle wins over the drain's clear.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_valid    <= 1'b0;
            r_entry    <= '0;
            r_fwd_strb <= 4'b0;
            r_fwd_data <= 32'h0;
        end else begin
            if (i_load) begin
                r_valid       <= 1'b1;
                r_entry.waddr <= i_load_waddr;
                r_entry.data  <= i_load_data;
                r_entry.strb  <= i_load_strb;
            end else if (i_drain) begin
                r_valid <= 1'b0;
            end
            // Snapshot taken before any same-cycle write lands, so reads see the older value.
            r_fwd_strb <= (i_snap && r_valid && (r_entry.waddr == i_rd_waddr)) ? r_entry.strb : 4'b0;
            r_fwd_data <= r_entry.data;
        end
    end

    always_comb begin
        o_merged_c = i_sram_rdata;
        for (int b = 0; b < 4; b++) begin
            if (r_fwd_strb[b]) begin
                o_merged_c[8*b +: 8] = r_fwd_data[8*b +: 8];
            end
        end
    end

    assign o_valid = r_valid;
    assign o_waddr = r_entry.waddr;
    assign o_data  = r_entry.data;
    assign o_strb  = r_entry.strb;

endmodule

// File: rtl/dmem_sram_bridge.sv
// Bridges the core's split read/write data ports onto one single-port SRAM.
// Reads own the port; buffered writes drain in spare cycles or when starved.
module dmem_sram_bridge
    import dmem_sram_bridge_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = DMEM_MEM_WORDS_DEFAULT,
    parameter int unsigned STARVE_MAX = DMEM_STARVE_MAX_DEFAULT
)(
    input  logic                         clk,
    input  logic                         resetb,
    input  logic                         dmem_wready,
    input  logic [31:0]                  dmem_waddr,
    input  logic [31:0]                  dmem_wdata,
    input  logic [3:0]                   dmem_wstrb,
    output logic                         dmem_wvalid,
    input  logic                         dmem_rready,
    input  logic [31:0]                  dmem_raddr,
    output logic                         dmem_rvalid,
    output logic                         dmem_rresp,
    output logic [31:0]                  dmem_rdata,
    output logic                         sram_ce,
    output logic [3:0]                   sram_we,
    output logic [$clog2(MEM_WORDS)-1:0] sram_addr,
    output logic [31:0]                  sram_wdata,
    input  logic [31:0]                  sram_rdata
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    logic [DMEM_WADDR_W-1:0] w_rd_waddr;
    logic [DMEM_WADDR_W-1:0] w_wr_waddr;
    logic [DMEM_WADDR_W-1:0] w_buf_waddr;
    logic [31:0]             w_buf_data;
    logic [3:0]              w_buf_strb;
    logic [31:0]             w_merged;
    logic                    w_buf_valid;
    logic                    w_rd_ok;
    logic                    w_wr_ok;
    logic                    w_force;
    logic                    w_rd_accept;
    logic                    w_rd_port;
    logic                    w_drain;
    logic                    w_load;
    logic [3:0]              w_unused_addr_bits;

    logic                    r_rvalid;
    logic                    r_rresp;
    logic                    r_rd_sram;
    logic [CW-1:0]           r_starve;

    assign w_rd_waddr         = dmem_raddr[31:2];
    assign w_wr_waddr         = dmem_waddr[31:2];
    assign w_unused_addr_bits = {dmem_raddr[1:0], dmem_waddr[1:0]};
    assign w_rd_ok            = dmem_addr_ok(w_rd_waddr, MEM_WORDS);
    assign w_wr_ok            = dmem_addr_ok(w_wr_waddr, MEM_WORDS);

    // Port arbitration; everything is held off while reset is asserted.
    assign w_force     = w_buf_valid && (r_starve == CW'(STARVE_MAX));
    assign w_rd_accept = resetb && dmem_rready && !w_force;
    assign w_rd_port   = w_rd_accept && w_rd_ok;
    assign w_drain     = resetb && w_buf_valid && !w_rd_port;
    assign dmem_wvalid = resetb && dmem_wready && (!w_buf_valid || w_drain);
    assign w_load      = dmem_wvalid && w_wr_ok && (dmem_wstrb != 4'b0);

    dmem_wbuf u_wbuf (
        .clk          (clk),
        .resetb       (resetb),
        .i_load       (w_load),
        .i_load_waddr (w_wr_waddr),
        .i_load_data  (dmem_wdata),
        .i_load_strb  (dmem_wstrb),
        .i_drain      (w_drain),
        .i_snap       (w_rd_port),
        .i_rd_waddr   (w_rd_waddr),
        .i_sram_rdata (sram_rdata),
        .o_valid      (w_buf_valid),
        .o_waddr      (w_buf_waddr),
        .o_data       (w_buf_data),
        .o_strb       (w_buf_strb),
        .o_merged_c   (w_merged)
    );

    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 4'b0;
        sram_addr  = '0;
        sram_wdata = 32'h0;
        if (w_rd_port) begin
            sram_ce   = 1'b1;
            sram_addr = AW'(w_rd_waddr);
        end else if (w_drain) begin
            sram_ce    = 1'b1;
            sram_we    = w_buf_strb;
            sram_addr  = AW'(w_buf_waddr);
            sram_wdata = w_buf_data;
        end
    end

    // Read response tracking and the write-starvation counter.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_rvalid  <= 1'b0;
            r_rresp   <= 1'b1;
            r_rd_sram <= 1'b0;
            r_starve  <= '0;
        end else begin
            r_rvalid  <= w_rd_accept;
            r_rresp   <= w_rd_accept ? w_rd_ok : 1'b1;
            r_rd_sram <= w_rd_port;
            if (!w_buf_valid || w_drain) begin
                r_starve <= '0;
            end else if (w_rd_port && (r_starve != CW'(STARVE_MAX))) begin
                r_starve <= r_starve + CW'(1);
            end
        end
    end

    assign dmem_rvalid = r_rvalid;
    assign dmem_rresp  = r_rresp;
    assign dmem_rdata  = r_rd_sram ? w_merged : 32'h0;

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Directed and random checks of dmem_sram_bridge against a memory-level reference model.
module tb_dmem_sram_bridge;

    localparam int unsigned MEM_WORDS  = 16384;
    localparam int unsigned STARVE_MAX = 8;

    logic        clk = 1'b0;
    logic        resetb;
    logic        dmem_wready;
    logic [31:0] dmem_waddr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_wvalid;
    logic        dmem_rready;
    logic [31:0] dmem_raddr;
    logic        dmem_rvalid;
    logic        dmem_rresp;
    logic [31:0] dmem_rdata;
    logic        sram_ce;
    logic [3:0]  sram_we;
    logic [13:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    always #5 clk = ~clk;

    dmem_sram_bridge #(.MEM_WORDS(MEM_WORDS), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .resetb(resetb),
        .dmem_wready(dmem_wready), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_wvalid(dmem_wvalid),
        .dmem_rready(dmem_rready), .dmem_raddr(dmem_raddr), .dmem_rvalid(dmem_rvalid),
        .dmem_rresp(dmem_rresp), .dmem_rdata(dmem_rdata),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    function automatic logic [31:0] init_word(input int w);
        if (w == 32'h80) return 32'h12345678;
        return {16'(w) ^ 16'h5A5A, 16'(w)};
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] nw,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // SRAM model: untouched words read back as init_word().
    logic [31:0]          sram_mem [MEM_WORDS];
    logic [MEM_WORDS-1:0] sram_written = '0;
    int                   n_watch_wr   = 0;

    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we != 4'b0) begin
                sram_mem[sram_addr]     <= merge_word(sram_written[sram_addr] ? sram_mem[sram_addr]
                                                      : init_word(int'(sram_addr)), sram_wdata, sram_we);
                sram_written[sram_addr] <= 1'b1;
                if (sram_addr == 14'h140) n_watch_wr <= n_watch_wr + 1;
            end else begin
                sram_rdata <= sram_written[sram_addr] ? sram_mem[sram_addr] : init_word(int'(sram_addr));
            end
        end
    end

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference: committed memory plus at most one posted write not yet in SRAM.
    logic [31:0] ref_mem [int];
    logic        m_pend;
    int unsigned m_age;
    int          m_addr;
    logic [31:0] m_data;
    logic [3:0]  m_strb;

    logic        last_wvalid, last_ce, last_rvalid, last_rresp, last_acc;
    logic [3:0]  last_we;
    logic [13:0] last_addr;
    logic [31:0] last_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input int w);
        logic [31:0] v;
        v = ref_mem.exists(w) ? ref_mem[w] : init_word(w);
        if (m_pend && m_addr == w) v = merge_word(v, m_data, m_strb);
        return v;
    endfunction

    task automatic cycle(input logic rr, input logic [31:0] ra, input logic wr,
                         input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws);
        int          rw, ww;
        logic        rd_ok, wr_ok, force_d, acc, port, drain, exp_wv;
        logic [31:0] exp_rd;
        dmem_rready = rr; dmem_raddr = ra;
        dmem_wready = wr; dmem_waddr = wa; dmem_wdata = wd; dmem_wstrb = ws;
        rw = int'(ra[31:2]);
        ww = int'(wa[31:2]);
        rd_ok = rw < int'(MEM_WORDS);
        wr_ok = ww < int'(MEM_WORDS);
        #4;
        force_d = m_pend && (m_age == STARVE_MAX);
        acc     = rr && !force_d;
        port    = acc && rd_ok;
        drain   = m_pend && !port;
        exp_wv  = wr && (!m_pend || drain);
        exp_rd  = rd_ok ? ref_read(rw) : 32'h0;
        chk("wvalid", 32'(dmem_wvalid), 32'(exp_wv));
        chk("sram_ce", 32'(sram_ce), 32'(port || drain));
        if (drain) begin
            chk("drain_we", 32'(sram_we), 32'(m_strb));
            chk("drain_addr", 32'(sram_addr), 32'(m_addr));
            chk("drain_wdata", sram_wdata, m_data);
        end else if (port) begin
            chk("read_we", 32'(sram_we), 32'h0);
            chk("read_addr", 32'(sram_addr), 32'(rw));
        end
        last_wvalid = dmem_wvalid; last_ce = sram_ce; last_we = sram_we; last_addr = sram_addr;
        @(posedge clk); #1;
        if (drain) begin
            ref_mem[m_addr] = merge_word(ref_mem.exists(m_addr) ? ref_mem[m_addr] : init_word(m_addr),
                                         m_data, m_strb);
            m_pend = 1'b0;
        end else if (m_pend) begin
            m_age++;
        end
        if (exp_wv && wr_ok && ws != 4'b0) begin
            m_pend = 1'b1; m_age = 0; m_addr = ww; m_data = wd; m_strb = ws;
        end
        chk("rvalid", 32'(dmem_rvalid), 32'(acc));
        if (acc) begin
            chk("rresp", 32'(dmem_rresp), 32'(rd_ok));
            chk("rdata", dmem_rdata, exp_rd);
        end
        last_rvalid = dmem_rvalid; last_rresp = dmem_rresp; last_rdata = dmem_rdata; last_acc = acc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset(input int edges);
        resetb = 1'b0;
        dmem_rready = 1'b0; dmem_raddr = 32'h0;
        dmem_wready = 1'b0; dmem_waddr = 32'h0; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
        repeat (edges) @(posedge clk);
        #1;
        chk("rst_rvalid", 32'(dmem_rvalid), 32'h0);
        chk("rst_rresp", 32'(dmem_rresp), 32'h1);
        chk("rst_rdata", dmem_rdata, 32'h0);
        chk("rst_ce", 32'(sram_ce), 32'h0);
        resetb = 1'b1;
        m_pend = 1'b0; m_age = 0;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [29:0] w;
        case ($urandom_range(0, 6))
            0:       w = 30'h40;
            1:       w = 30'h41;
            2:       w = 30'h80;
            3:       w = 30'hC1;
            4:       w = 30'h3FFF;
            5:       w = 30'h4000;
            default: w = 30'h81;
        endcase
        return {w, 2'($urandom_range(0, 3))};
    endfunction

    initial begin
        logic        hold_r, hold_w, rr, wr;
        logic [31:0] ra, wa, wd;
        logic [3:0]  ws;
        int          zero_cnt, first_zero, first_wv, bad_sram_wr;
        m_pend = 1'b0; m_age = 0; m_addr = 0; m_data = 32'h0; m_strb = 4'h0;
        do_reset(2);

        // Posted write drains on the next idle cycle.
        cycle(1'b0, 32'h0, 1'b1, 32'h100, 32'h11223344, 4'hF);
        chk("w037_wvalid", 32'(last_wvalid), 32'h1);
        idle(1);
        chk("w037_ce", 32'(last_ce), 32'h1);
        chk("w037_we", 32'(last_we), 32'hF);
        chk("w037_addr", 32'(last_addr), 32'h40);

        // Partial write forwarded into an immediate read.
        cycle(1'b0, 32'h0, 1'b1, 32'h200, 32'hAABBCCDD, 4'h3);
        cycle(1'b1, 32'h200, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("r038_rvalid", 32'(last_rvalid), 32'h1);
        chk("r038_rdata", last_rdata, 32'h1234CCDD);
        idle(1);

        // Same-cycle read and write to one word: read sees the older value.
        cycle(1'b1, 32'h304, 1'b1, 32'h304, 32'hDEADBEEF, 4'hF);
        chk("r027_rdata", last_rdata, init_word(32'hC1));
        idle(1);

        // Continuous reads starve a buffered write until the forced drain.
        cycle(1'b0, 32'h0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF);
        zero_cnt = 0; first_zero = 0;
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b1, 32'h600, 1'b0, 32'h0, 32'h0, 4'h0);
            if (!last_rvalid) begin
                zero_cnt++;
                if (first_zero == 0) first_zero = i;
            end
        end
        chk("r039_gap_count", 32'(zero_cnt), 32'h1);
        chk("r039_gap_cycle", 32'(first_zero), 32'(STARVE_MAX + 1));

        // A second write waits for the forced drain cycle.
        cycle(1'b0, 32'h0, 1'b1, 32'h700, 32'h55667788, 4'hF);
        first_wv = 0;
        for (int i = 1; i <= 9; i++) begin
            cycle(1'b1, 32'h604, 1'b1, 32'h800, 32'h01020304, 4'hF);
            if (last_wvalid && first_wv == 0) first_wv = i;
        end
        chk("r040_first_wvalid", 32'(first_wv), 32'(STARVE_MAX + 1));
        idle(2);

        // Out-of-range read and discarded writes.
        cycle(1'b1, 32'(4 * MEM_WORDS), 1'b0, 32'h0, 32'h0, 4'h0);
        chk("r041_ce", 32'(last_ce), 32'h0);
        chk("r041_rresp", 32'(last_rresp), 32'h0);
        chk("r041_rdata", last_rdata, 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 32'(4 * MEM_WORDS), 32'h99999999, 4'hF);
        idle(1);
        chk("oor_write_no_drain", 32'(last_ce), 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 32'h900, 32'h77777777, 4'h0);
        chk("strb0_wvalid", 32'(last_wvalid), 32'h1);
        idle(1);
        chk("strb0_no_drain", 32'(last_ce), 32'h0);

        // Reset discards a buffered write.
        cycle(1'b0, 32'h0, 1'b1, 32'h500, 32'hBADBAD00, 4'hF);
        do_reset(1);
        idle(2);
        cycle(1'b1, 32'h500, 1'b0, 32'h0, 32'h0, 4'h0);

        // Random traffic; the core holds requests that were not taken.
        hold_r = 1'b0; hold_w = 1'b0;
        rr = 1'b0; wr = 1'b0; ra = 32'h0; wa = 32'h0; wd = 32'h0; ws = 4'h0;
        for (int i = 0; i < 600; i++) begin
            if (!hold_r) begin
                rr = ($urandom_range(0, 3) != 0);
                ra = rnd_addr();
            end
            if (!hold_w) begin
                wr = ($urandom_range(0, 2) == 0);
                wa = rnd_addr();
                wd = $urandom;
                ws = 4'($urandom_range(0, 15));
            end
            cycle(rr, ra, wr, wa, wd, ws);
            hold_r = rr && !last_acc;
            hold_w = wr && !last_wvalid;
        end
        idle(3);

        foreach (ref_mem[k]) begin
            chk($sformatf("final_mem_%0h", k),
                sram_written[k] ? sram_mem[k] : init_word(k), ref_mem[k]);
        end
        bad_sram_wr = n_watch_wr;
        chk("r042_no_sram_write", 32'(bad_sram_wr), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
